cp0_intc: RTL and testbench
===========================

// Module: cp0_intc
// PURPOSE
// - Parametrised CP0 for the MIPS microsystem: SR/Cause/EPC/PRId, Count/Compare timer, interrupt controller.
// - Synchronises async hw interrupt lines, per-line edge/level mode, software interrupts.
// - EPC with branch-delay correction; raises intreq to the CPU controller; holds EPC for eret.
// PARAMETERS
// - NUM_HWINT  6             hw interrupt lines (1..6); line i -> Cause.IP[10+i]
// - IRQ_EDGE   6'b000000     per-line mode; 1 = rising-edge latched (sticky), 0 = level
// - TIMER_EN   0             1 = timer drives IP[15]; requires NUM_HWINT<=5
// - PRID       32'h0018_0711 PRId read value
// PORTS
// - clk        in  1  clock
// - reset      in  1  synchronous, active-high reset
// - we         in  1  mtc0 write strobe
// - regaddr    in  5  CP0 register number (9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId)
// - datain     in  32 mtc0 write data
// - dataout    out 32 mfc0 read data (combinational)
// - exlset     in  1  exception/interrupt entry pulse
// - exlclr     in  1  eret pulse
// - excode_in  in  5  ExcCode captured on exlset (0 = interrupt)
// - bd_in      in  1  faulting instruction sits in a branch delay slot
// - pcin       in  32 PC of the faulting/interrupted instruction
// - hwint      in  NUM_HWINT async interrupt lines
// - intreq     out 1  interrupt request to the CPU
// - int_id     out 3  index of the highest pending enabled IP bit (IP[15] highest), minus 8
// - epcout     out 32 current EPC
// BEHAVIOUR
// - Reset: SR, Cause, EPC, Count, Compare, sync/edge flops = 0. Outputs intreq=0, int_id=0, epcout=0.
// - SR: IM[15:8], EXL[1], IE[0]. Other bits read 0. mtc0 SR writes only these bits.
// - Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2].
//   - IP[9:8] are sw interrupts, rw via mtc0.
//   - hw IP bits: edge-mode bits are W1C via mtc0; level-mode bits are read-only.
//   - Unused IP bits read 0.
// - hwint path: 2-flop synchroniser.
//   - Level line: IP = synced value.
//   - Edge line: IP set on synced 0->1 and held until W1C. An edge and a W1C in the same cycle leave the bit set.
//   - Assertion -> IP visible 3 cycles later.
// - intreq = |(IP & IM) & IE & ~EXL, combinational from registers.
//   - int_id is valid only while intreq=1; otherwise 0.
// - exlset:
//   - EXL<=1, ExcCode<=excode_in, BD<=bd_in.
//   - EPC<=bd_in ? pcin-4 : pcin, but only if EXL was 0. If EXL was already 1, EPC and BD are kept.
// - exlclr: EXL<=0. exlset and exlclr in the same cycle: exlset wins.
// - mtc0 in the same cycle as exlset: EXL, EPC, BD and ExcCode take the exlset values; all other fields take the write.
// - Timer (TIMER_EN=1):
//   - Count += 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
//   - Count==Compare sets TI and IP[15]; both are sticky.
//   - mtc0 Compare clears TI. mtc0 Count loads Count and suppresses that cycle's increment.
// - Timer (TIMER_EN=0): Count and Compare read 0, writes ignored.
// - Reads: 9/11/12/13/14 return the register; 15 returns PRID; any other address returns 0. No latches.
// STRUCTURE
// - Package cp0_pkg: register numbers, SR/Cause bit positions, EXC_INT=0, EXC_SYS=8, EXC_OV=12.
// - Sub-module cp0_irq_sync: per-line synchroniser plus edge detector, generated NUM_HWINT times.
// - Top: register file, W1C/priority logic, timer.
// TESTING
// - Reset, read 15/12/13 -> 32'h0018_0711, 0, 0; intreq=0.
// - IRQ_EDGE[0]=1; mtc0 SR=32'h0000_0401; 1-cycle pulse on hwint[0]
//   -> IP10 set 3 cycles later; intreq=1; int_id=2.
//   - Then exlset, pcin=32'h3000, excode 0 -> EPC=32'h3000, EXL=1, intreq=0.
// - Nested: exlset with EXL=1, pcin=32'h4000 -> EPC stays 32'h3000.
//   - Then exlclr -> EXL=0 and intreq=1 again (IP10 still pending).
//   - mtc0 Cause=32'h400 -> IP10=0, intreq=0.
// - Delay slot: exlset, bd_in=1, pcin=32'h3008 -> EPC=32'h3004, Cause[31]=1.
//   - Same cycle exlset+exlclr -> EXL=1.
// - TIMER_EN=1, NUM_HWINT=5: mtc0 Compare=10, Count=0
//   -> TI and IP15 set when Count==10; then mtc0 Compare=20 -> TI=0, IP15=0.
// - Level line held high with IM set: W1C write to Cause -> IP stays 1; deassert hwint -> IP=0 3 cycles later.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 register numbers, status/cause field positions and exception codes
// shared by the interrupt controller and anything decoding CP0 state.
package cp0_pkg;

  typedef enum logic [4:0] {
    REG_COUNT   = 5'd9,
    REG_COMPARE = 5'd11,
    REG_SR      = 5'd12,
    REG_CAUSE   = 5'd13,
    REG_EPC     = 5'd14,
    REG_PRID    = 5'd15
  } cp0_reg_e;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Restart address: a faulting delay-slot instruction resumes at its branch.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line, plus a
// registered copy of the synced value for rising-edge detection.
module cp0_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  output logic irq_level,
  output logic irq_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = irq_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign irq_level = sync_q;
  assign irq_rise  = sync_q & ~prev_q;

endmodule

// File: rtl/cp0_intc.sv
// CP0 for the MIPS microsystem: SR/Cause/EPC/PRId, optional Count/Compare
// timer and the hardware/software interrupt controller feeding the CPU.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [5:0]  IRQ_EDGE  = 6'b000000,
  parameter bit          TIMER_EN  = 1'b0,
  parameter logic [31:0] PRID      = 32'h0018_0711
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           regaddr,
  input  logic [31:0]          datain,
  output logic [31:0]          dataout,
  input  logic                 exlset,
  input  logic                 exlclr,
  input  logic [4:0]           excode_in,
  input  logic                 bd_in,
  input  logic [31:0]          pcin,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 intreq,
  output logic [2:0]           int_id,
  output logic [31:0]          epcout
);

  logic [5:0] hw_level, hw_rise;

  for (genvar i = 0; i < 6; i++) begin : g_line
    if (i < NUM_HWINT) begin : g_sync
      cp0_irq_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .irq_async (hwint[i]),
        .irq_level (hw_level[i]),
        .irq_rise  (hw_rise[i])
      );
    end else begin : g_tie
      assign hw_level[i] = 1'b0;
      assign hw_rise[i]  = 1'b0;
    end
  end

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic [5:0]  hw_ip_q, hw_ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;

  logic wr_sr, wr_cause, wr_epc, wr_count, wr_compare;
  logic [7:0] ip, pend;

  always_comb begin
    wr_sr      = we && (regaddr == REG_SR);
    wr_cause   = we && (regaddr == REG_CAUSE);
    wr_epc     = we && (regaddr == REG_EPC);
    wr_count   = we && (regaddr == REG_COUNT);
    wr_compare = we && (regaddr == REG_COMPARE);
  end

  // Hardware IP bits: level lines follow the synchroniser, edge lines are
  // sticky until written-1-to-clear, with a new edge beating the clear.
  always_comb begin
    hw_ip_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (i >= NUM_HWINT || (TIMER_EN && i == 5)) begin
        hw_ip_d[i] = 1'b0;
      end else if (IRQ_EDGE[i]) begin
        hw_ip_d[i] = (hw_ip_q[i] & ~(wr_cause & datain[CAUSE_IP_LO+2+i])) | hw_rise[i];
      end else begin
        hw_ip_d[i] = hw_level[i];
      end
    end
  end

  always_comb begin
    im_d      = im_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    sw_ip_d   = sw_ip_q;
    epc_d     = epc_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    if (wr_sr) begin
      im_d  = datain[SR_IM_LO +: 8];
      ie_d  = datain[SR_IE];
      exl_d = datain[SR_EXL];
    end
    if (wr_cause) sw_ip_d = datain[CAUSE_IP_LO +: 2];
    if (wr_epc)   epc_d   = datain;
    if (exlclr)   exl_d   = 1'b0;
    // Exception entry overrides any same-cycle mtc0 to EXL/EPC; a nested
    // entry keeps the outer restart point.
    if (exlset) begin
      exl_d     = 1'b1;
      exccode_d = excode_in;
      if (!exl_q) begin
        epc_d = epc_target(pcin, bd_in);
        bd_d  = bd_in;
      end
    end
  end

  always_comb begin
    count_d   = '0;
    compare_d = '0;
    ti_d      = 1'b0;
    if (TIMER_EN) begin
      count_d   = wr_count ? datain : count_q + 32'd1;
      compare_d = wr_compare ? datain : compare_q;
      ti_d      = wr_compare ? 1'b0 : (ti_q | (count_q == compare_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      sw_ip_q   <= '0;
      hw_ip_q   <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      im_q      <= im_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      sw_ip_q   <= sw_ip_d;
      hw_ip_q   <= hw_ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  always_comb begin
    ip = {hw_ip_q, sw_ip_q};
    if (TIMER_EN) ip[7] = ti_q;
    pend = ip & im_q;
  end

  always_comb begin
    intreq = (|pend) & ie_q & ~exl_q;
    int_id = 3'd0;
    if (intreq) begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) int_id = 3'(i);
      end
    end
  end

  always_comb begin
    dataout = '0;
    case (regaddr)
      REG_COUNT:   dataout = count_q;
      REG_COMPARE: dataout = compare_q;
      REG_SR:      dataout = {16'b0, im_q, 6'b0, exl_q, ie_q};
      REG_CAUSE:   dataout = {bd_q, ti_q & TIMER_EN, 14'b0, ip, 1'b0, exccode_q, 2'b0};
      REG_EPC:     dataout = epc_q;
      REG_PRID:    dataout = PRID;
      default:     dataout = '0;
    endcase
  end

  assign epcout = epc_q;

  logic unused_hw;
  assign unused_hw = ^{hw_level, hw_rise};

endmodule

// File: tb/tb_cp0_intc.sv
// Bench for cp0_intc: a register/interrupt vector table plus directed
// sequences for exception entry, edge/level lines and the timer.
module tb_cp0_intc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: no timer, line 0 edge-mode, line 1 level-mode
  logic        a_we, a_exlset, a_exlclr, a_bd, a_intreq;
  logic [4:0]  a_regaddr, a_excode;
  logic [31:0] a_datain, a_dataout, a_pcin, a_epcout;
  logic [5:0]  a_hwint;
  logic [2:0]  a_int_id;

  cp0_intc #(.NUM_HWINT(6), .IRQ_EDGE(6'b000001), .TIMER_EN(1'b0), .PRID(32'h0018_0711)) u_a (
    .clk(clk), .reset(reset), .we(a_we), .regaddr(a_regaddr), .datain(a_datain),
    .dataout(a_dataout), .exlset(a_exlset), .exlclr(a_exlclr), .excode_in(a_excode),
    .bd_in(a_bd), .pcin(a_pcin), .hwint(a_hwint), .intreq(a_intreq), .int_id(a_int_id),
    .epcout(a_epcout)
  );

  // Instance B: timer enabled on IP15, five hardware lines
  logic        b_we, b_exlset, b_exlclr, b_bd, b_intreq;
  logic [4:0]  b_regaddr, b_excode;
  logic [31:0] b_datain, b_dataout, b_pcin, b_epcout;
  logic [4:0]  b_hwint;
  logic [2:0]  b_int_id;

  cp0_intc #(.NUM_HWINT(5), .IRQ_EDGE(6'b000000), .TIMER_EN(1'b1), .PRID(32'h0018_0711)) u_b (
    .clk(clk), .reset(reset), .we(b_we), .regaddr(b_regaddr), .datain(b_datain),
    .dataout(b_dataout), .exlset(b_exlset), .exlclr(b_exlclr), .excode_in(b_excode),
    .bd_in(b_bd), .pcin(b_pcin), .hwint(b_hwint), .intreq(b_intreq), .int_id(b_int_id),
    .epcout(b_epcout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rexp;
    logic        ireq;
    logic [2:0]  iid;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input logic [4:0] addr, output logic [31:0] d);
    a_regaddr = addr;
    #1;
    d = a_dataout;
  endtask

  task automatic rd_b(input logic [4:0] addr, output logic [31:0] d);
    b_regaddr = addr;
    #1;
    d = b_dataout;
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [31:0] d);
    a_we = 1'b1; a_regaddr = addr; a_datain = d;
    step();
    a_we = 1'b0;
  endtask

  task automatic wr_b(input logic [4:0] addr, input logic [31:0] d);
    b_we = 1'b1; b_regaddr = addr; b_datain = d;
    step();
    b_we = 1'b0;
  endtask

  task automatic exc_a(input logic [31:0] pc, input logic [4:0] code, input logic bd, input logic clr);
    a_exlset = 1'b1; a_pcin = pc; a_excode = code; a_bd = bd; a_exlclr = clr;
    step();
    a_exlset = 1'b0; a_exlclr = 1'b0; a_bd = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,         5'd15, 32'h0018_0711, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0,         1'b0, 3'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0,         1'b0, 3'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0,         1'b0, 3'd0};
    vecs[4]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0000_FF03, 1'b0, 3'd0};
    vecs[5]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 5'd12, 32'h0000_0201, 5'd12, 32'h0000_0201, 1'b1, 3'd1};
    vecs[7]  = '{1'b1, 5'd12, 32'h0000_0301, 5'd13, 32'h0000_0300, 1'b1, 3'd1};
    vecs[8]  = '{1'b1, 5'd13, 32'h0000_0100, 5'd13, 32'h0000_0100, 1'b1, 3'd0};
    vecs[9]  = '{1'b1, 5'd13, 32'h0,         5'd13, 32'h0,         1'b0, 3'd0};
    vecs[10] = '{1'b1, 5'd9,  32'h0000_0055, 5'd9,  32'h0,         1'b0, 3'd0};
    vecs[11] = '{1'b1, 5'd11, 32'h0000_0055, 5'd11, 32'h0,         1'b0, 3'd0};
    vecs[12] = '{1'b1, 5'd14, 32'h0000_1234, 5'd14, 32'h0000_1234, 1'b0, 3'd0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         5'd7,  32'h0,         1'b0, 3'd0};
    vecs[14] = '{1'b1, 5'd12, 32'h0,         5'd12, 32'h0,         1'b0, 3'd0};

    a_we = 0; a_regaddr = 0; a_datain = 0; a_exlset = 0; a_exlclr = 0;
    a_excode = 0; a_bd = 0; a_pcin = 0; a_hwint = 0;
    b_we = 0; b_regaddr = 0; b_datain = 0; b_exlset = 0; b_exlclr = 0;
    b_excode = 0; b_bd = 0; b_pcin = 0; b_hwint = 0;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_intreq", {31'b0, a_intreq}, 32'h0);
    check("reset_int_id", {29'b0, a_int_id}, 32'h0);
    check("reset_epcout", a_epcout, 32'h0);

    for (int i = 0; i < 15; i++) begin
      a_we = vecs[i].we; a_regaddr = vecs[i].waddr; a_datain = vecs[i].wdata;
      step();
      a_we = 1'b0;
      rd_a(vecs[i].raddr, r);
      check($sformatf("vec%0d_data", i), r, vecs[i].rexp);
      check($sformatf("vec%0d_intreq", i), {31'b0, a_intreq}, {31'b0, vecs[i].ireq});
      check($sformatf("vec%0d_int_id", i), {29'b0, a_int_id}, {29'b0, vecs[i].iid});
    end

    // Edge line 0: one-cycle pulse appears in IP10 on the third edge
    wr_a(5'd12, 32'h0000_0401);
    a_hwint[0] = 1'b1;
    step();
    a_hwint[0] = 1'b0;
    step();
    rd_a(5'd13, r); check("edge_ip_early", r, 32'h0);
    step();
    rd_a(5'd13, r); check("edge_ip_set", r, 32'h0000_0400);
    check("edge_intreq", {31'b0, a_intreq}, 32'h1);
    check("edge_int_id", {29'b0, a_int_id}, 32'd2);

    exc_a(32'h3000, 5'd0, 1'b0, 1'b0);
    check("exc_epc", a_epcout, 32'h3000);
    rd_a(5'd12, r); check("exc_sr", r, 32'h0000_0403);
    check("exc_intreq", {31'b0, a_intreq}, 32'h0);

    exc_a(32'h4000, 5'd8, 1'b0, 1'b0);
    check("nest_epc", a_epcout, 32'h3000);
    rd_a(5'd13, r); check("nest_cause", r, 32'h0000_0420);

    a_exlclr = 1'b1; step(); a_exlclr = 1'b0;
    rd_a(5'd12, r); check("eret_sr", r, 32'h0000_0401);
    check("eret_intreq", {31'b0, a_intreq}, 32'h1);
    check("eret_int_id", {29'b0, a_int_id}, 32'd2);

    wr_a(5'd13, 32'h0000_0400);
    rd_a(5'd13, r); check("w1c_cause", r, 32'h0000_0020);
    check("w1c_intreq", {31'b0, a_intreq}, 32'h0);

    exc_a(32'h3008, 5'd12, 1'b1, 1'b0);
    check("bd_epc", a_epcout, 32'h3004);
    rd_a(5'd13, r); check("bd_cause", r, 32'h8000_0030);

    exc_a(32'h5000, 5'd12, 1'b0, 1'b1);
    rd_a(5'd12, r); check("setclr_sr", r, 32'h0000_0403);
    check("setclr_epc", a_epcout, 32'h3004);
    rd_a(5'd13, r); check("setclr_cause", r, 32'h8000_0030);

    // mtc0 SR racing an exception entry
    a_exlclr = 1'b1; step(); a_exlclr = 1'b0;
    a_we = 1'b1; a_regaddr = 5'd12; a_datain = 32'h0;
    exc_a(32'h6000, 5'd8, 1'b0, 1'b0);
    a_we = 1'b0;
    rd_a(5'd12, r); check("race_sr", r, 32'h0000_0002);
    check("race_epc", a_epcout, 32'h6000);
    rd_a(5'd13, r); check("race_cause", r, 32'h0000_0020);
    wr_a(5'd12, 32'h0);

    // Edge arriving in the same cycle as its W1C stays pending
    wr_a(5'd12, 32'h0000_0401);
    a_hwint[0] = 1'b1; step();
    a_hwint[0] = 1'b0; step();
    wr_a(5'd13, 32'h0000_0400);
    rd_a(5'd13, r); check("edge_w1c_race", r & 32'h0000_FF00, 32'h0000_0400);
    wr_a(5'd13, 32'h0000_0400);
    rd_a(5'd13, r); check("edge_w1c_clear", r & 32'h0000_FF00, 32'h0);

    // Level line 1 is read-only and follows the pin
    wr_a(5'd12, 32'h0000_0C01);
    a_hwint[1] = 1'b1;
    step(); step();
    rd_a(5'd13, r); check("lvl_early", r & 32'h0000_FF00, 32'h0);
    step();
    rd_a(5'd13, r); check("lvl_set", r & 32'h0000_FF00, 32'h0000_0800);
    check("lvl_int_id", {29'b0, a_int_id}, 32'd3);
    wr_a(5'd13, 32'h0000_0800);
    rd_a(5'd13, r); check("lvl_w1c_ignored", r & 32'h0000_FF00, 32'h0000_0800);
    a_hwint[1] = 1'b0;
    step(); step();
    rd_a(5'd13, r); check("lvl_hold", r & 32'h0000_FF00, 32'h0000_0800);
    step();
    rd_a(5'd13, r); check("lvl_clear", r & 32'h0000_FF00, 32'h0);
    check("lvl_intreq", {31'b0, a_intreq}, 32'h0);

    // Timer instance: Count==Compare(0) right after reset left TI pending
    wr_b(5'd12, 32'h0000_8001);
    check("tmr_reset_ti_intreq", {31'b0, b_intreq}, 32'h1);
    check("tmr_reset_ti_id", {29'b0, b_int_id}, 32'd7);
    wr_b(5'd11, 32'd10);
    rd_b(5'd13, r); check("tmr_cmp_clear", r, 32'h0);
    wr_b(5'd9, 32'd0);
    rd_b(5'd9, r); check("tmr_count_load", r, 32'd0);
    repeat (10) step();
    rd_b(5'd9, r); check("tmr_count10", r, 32'd10);
    rd_b(5'd13, r); check("tmr_ti_not_yet", r, 32'h0);
    step();
    rd_b(5'd13, r); check("tmr_ti_set", r, 32'h4000_8000);
    check("tmr_intreq", {31'b0, b_intreq}, 32'h1);
    check("tmr_int_id", {29'b0, b_int_id}, 32'd7);
    step();
    rd_b(5'd13, r); check("tmr_ti_sticky", r, 32'h4000_8000);
    wr_b(5'd11, 32'd20);
    rd_b(5'd13, r); check("tmr_ti_cleared", r, 32'h0);
    check("tmr_intreq_clr", {31'b0, b_intreq}, 32'h0);
    rd_b(5'd11, r); check("tmr_compare_rd", r, 32'd20);
    wr_b(5'd9, 32'hFFFF_FFFF);
    rd_b(5'd9, r); check("tmr_count_max", r, 32'hFFFF_FFFF);
    step();
    rd_b(5'd9, r); check("tmr_wrap", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
